mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a shared single-port RAM. It issues combinational grants,
// uses a fixed-latency tag pipeline to route read data, and squashes stale fetches on flush.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        Clock,
    input  logic        Reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    input  logic        flush,

    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t                 state;
    logic [3:0]             starve_cnt;
    logic [MEM_LATENCY-1:0] tag_valid;
    logic [MEM_LATENCY-1:0] tag_src;

    logic fetch_open;
    logic fetch_force;
    logic tag_new_valid;
    logic ret_valid;
    logic ret_fetch;

    // Word-aligned RAM: the byte-offset bits of both addresses are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    always_comb begin
        fetch_open  = Reset && (state == RUN);
        fetch_force = ({28'd0, starve_cnt} >= STARVE_LIMIT);

        // Data has priority unless fetch has starved long enough.
        i_gnt = fetch_open && i_req && (!d_req || fetch_force);
        d_gnt = Reset && d_req && !i_gnt;

        mem_en    = i_gnt || d_gnt;
        mem_we    = d_gnt ? d_we : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        if (d_gnt) begin
            mem_addr = d_addr[31:2];
        end else if (i_gnt) begin
            mem_addr = i_addr[31:2];
        end else begin
            mem_addr = '0;
        end

        tag_new_valid = i_gnt || (d_gnt && (d_we == 4'b0000));

        ret_valid = Reset && tag_valid[MEM_LATENCY-1];
        ret_fetch = tag_src[MEM_LATENCY-1];
        i_rvalid  = ret_valid && ret_fetch;
        d_rvalid  = ret_valid && !ret_fetch;
        i_rdata   = i_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= RUN;
            starve_cnt <= '0;
            tag_valid  <= '0;
            tag_src    <= '0;
        end else begin
            // A flush in either state (re)starts the one-cycle fetch blackout.
            state <= flush ? SQUASH : RUN;

            if (!i_req || i_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            // The grant issued this cycle enters unsquashed; only older fetch tags are killed.
            tag_valid[0] <= tag_new_valid;
            tag_src[0]   <= i_gnt;
            for (int unsigned k = 1; k < MEM_LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1] && !(flush && tag_src[k-1]);
                tag_src[k]   <= tag_src[k-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (latency 2 and 3) share one stimulus stream.
module tb_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        flush;
    logic [31:0] mem_rdata;

    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_en;
    logic [31:0] a_i_rdata, a_d_rdata, a_mem_wdata;
    logic [3:0]  a_mem_we;
    logic [29:0] a_mem_addr;

    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_en;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_wdata;
    logic [3:0]  b_mem_we;
    logic [29:0] b_mem_addr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 Clock = ~Clock;

    mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) u_lat2 (
        .Clock(Clock), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .flush(flush),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_lat3 (
        .Clock(Clock), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .flush(flush),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        mem_rdata = 32'hC0DE_0000 + 32'(cyc);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = '0;
        d_we = '0; d_wdata = '0; flush = 1'b0; mem_rdata = '0;

        // Requests during reset are ignored, outputs are quiet.
        tick(); tick(); #1;
        chk("rst_i_gnt", a_i_gnt, 0);
        chk("rst_d_gnt", a_d_gnt, 0);
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        chk("rst_mem_wdata", a_mem_wdata, 0);
        Reset = 1'b1; i_req = 1'b0; d_req = 1'b0;

        // Single fetch: grant same cycle, return after latency.
        tick(); i_req = 1'b1; i_addr = 32'h100; #1;
        chk("fetch_i_gnt", a_i_gnt, 1);
        chk("fetch_mem_en", a_mem_en, 1);
        chk("fetch_mem_addr", a_mem_addr, 32'h40);
        chk("fetch_mem_we", a_mem_we, 0);
        chk("fetch_d_gnt", a_d_gnt, 0);
        tick(); i_req = 1'b0; #1;
        chk("fetch_early_rvalid", a_i_rvalid, 0);
        chk("fetch_idle_rdata", a_i_rdata, 0);
        tick(); #1;
        chk("fetch_l2_rvalid", a_i_rvalid, 1);
        chk("fetch_l2_rdata", a_i_rdata, mem_rdata);
        chk("fetch_l3_early", b_i_rvalid, 0);
        tick(); #1;
        chk("fetch_l3_rvalid", b_i_rvalid, 1);
        chk("fetch_l3_rdata", b_i_rdata, mem_rdata);
        chk("fetch_l2_done", a_i_rvalid, 0);

        // Store: write strobes and data forwarded, no return.
        tick(); d_req = 1'b1; d_we = 4'hF; d_addr = 32'h204; d_wdata = 32'hDEADBEEF; #1;
        chk("st_d_gnt", a_d_gnt, 1);
        chk("st_mem_we", a_mem_we, 32'hF);
        chk("st_mem_addr", a_mem_addr, 32'h81);
        chk("st_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
        chk("st_i_gnt", a_i_gnt, 0);
        tick(); d_req = 1'b0; d_we = '0; d_wdata = '0; #1;
        chk("st_idle_mem_en", a_mem_en, 0);
        tick(); #1;
        chk("st_l2_no_rvalid", a_d_rvalid, 0);
        tick(); #1;
        chk("st_l3_no_rvalid", b_d_rvalid, 0);

        // Starvation: data wins 4 cycles, fetch forced on the 5th, data again.
        i_addr = 32'h300; d_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            tick(); i_req = 1'b1; d_req = 1'b1; #1;
            chk("starve_i_gnt", a_i_gnt, 32'(k == 4));
            chk("starve_d_gnt", a_d_gnt, 32'(k != 4));
            chk("starve_mem_addr", a_mem_addr, (k == 4) ? 32'hC0 : 32'h100);
        end
        tick(); i_req = 1'b0; d_req = 1'b0; #1;
        chk("starve_ret_a_i", a_i_rvalid, 1);
        chk("starve_ret_a_d", a_d_rvalid, 0);
        chk("starve_ret_b_d", b_d_rvalid, 1);
        chk("starve_ret_b_i", b_i_rvalid, 0);
        tick(); #1;
        chk("starve_ret2_a_d", a_d_rvalid, 1);
        chk("starve_ret2_a_rdata", a_d_rdata, mem_rdata);
        chk("starve_ret2_b_i", b_i_rvalid, 1);
        tick(); #1;
        chk("starve_ret3_b_d", b_d_rvalid, 1);
        chk("starve_ret3_a_d", a_d_rvalid, 0);
        tick();

        // Flush: F0 fetch squashed, F1 fetch (same cycle as flush) survives.
        tick(); i_req = 1'b1; i_addr = 32'h500; #1;
        chk("fl_f0_gnt", a_i_gnt, 1);
        tick(); i_addr = 32'h504; flush = 1'b1; #1;
        chk("fl_f1_gnt", a_i_gnt, 1);
        tick(); i_addr = 32'h508; flush = 1'b0; d_req = 1'b1; d_we = '0; d_addr = 32'h600; #1;
        chk("fl_squash_i_gnt", a_i_gnt, 0);
        chk("fl_squash_d_gnt", a_d_gnt, 1);
        chk("fl_f0_killed_a", a_i_rvalid, 0);
        tick(); d_req = 1'b0; #1;
        chk("fl_run_i_gnt", a_i_gnt, 1);
        chk("fl_f1_ret_a", a_i_rvalid, 1);
        chk("fl_f1_rdata_a", a_i_rdata, mem_rdata);
        chk("fl_f0_killed_b", b_i_rvalid, 0);
        tick(); i_req = 1'b0; #1;
        chk("fl_ld_ret_a", a_d_rvalid, 1);
        chk("fl_ld_ret_a_i", a_i_rvalid, 0);
        chk("fl_f1_ret_b", b_i_rvalid, 1);
        tick(); #1;
        chk("fl_f3_ret_a", a_i_rvalid, 1);
        chk("fl_ld_ret_b", b_d_rvalid, 1);
        tick(); #1;
        chk("fl_f3_ret_b", b_i_rvalid, 1);

        // Flush again while squashing: blackout extends, G0 fetch killed.
        tick(); i_req = 1'b1; i_addr = 32'h700; flush = 1'b1; #1;
        chk("ff_g0_gnt", a_i_gnt, 1);
        tick(); i_addr = 32'h704; #1;
        chk("ff_g1_gnt", a_i_gnt, 0);
        tick(); flush = 1'b0; #1;
        chk("ff_g2_gnt", a_i_gnt, 0);
        chk("ff_g0_killed_a", a_i_rvalid, 0);
        tick(); #1;
        chk("ff_g3_gnt", a_i_gnt, 1);
        chk("ff_g0_killed_b", b_i_rvalid, 0);
        tick(); i_req = 1'b0; #1;
        tick(); #1;
        chk("ff_g3_ret_a", a_i_rvalid, 1);
        tick(); #1;
        chk("ff_g3_ret_b", b_i_rvalid, 1);

        // Load in flight across a reset never returns.
        tick(); d_req = 1'b1; d_we = '0; d_addr = 32'h800; #1;
        chk("rr_ld_gnt", a_d_gnt, 1);
        tick(); d_req = 1'b0; i_req = 1'b1; Reset = 1'b0; #1;
        chk("rr_i_gnt", a_i_gnt, 0);
        chk("rr_mem_en", a_mem_en, 0);
        chk("rr_d_rvalid_b", b_d_rvalid, 0);
        tick(); Reset = 1'b1; i_req = 1'b0; #1;
        chk("rr_no_ret_a", a_d_rvalid, 0);
        tick(); #1;
        chk("rr_no_ret_b", b_d_rvalid, 0);
        chk("rr_no_ret_a2", a_d_rvalid, 0);

        // Alternating fetch/load: latency-3 returns follow issue order and source.
        for (int k = 0; k < 9; k++) begin
            tick();
            i_req  = (k < 6) && (k % 2 == 0);
            d_req  = (k < 6) && (k % 2 == 1);
            i_addr = 32'h1000 + 32'(k * 4);
            d_addr = 32'h2000 + 32'(k * 4);
            d_we   = '0;
            #1;
            if (k < 6) begin
                chk("alt_i_gnt", b_i_gnt, 32'(k % 2 == 0));
                chk("alt_d_gnt", b_d_gnt, 32'(k % 2 == 1));
            end
            if (k >= 3) begin
                chk("alt_i_rvalid", b_i_rvalid, 32'((k - 3) % 2 == 0));
                chk("alt_d_rvalid", b_d_rvalid, 32'((k - 3) % 2 == 1));
                if ((k - 3) % 2 == 0) chk("alt_i_rdata", b_i_rdata, mem_rdata);
                else                  chk("alt_d_rdata", b_d_rdata, mem_rdata);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
